rename_map_ckpt: RTL and testbench

RENAME_MAP_CKPT -- requirements
Module: rename_map_ckpt

---
 rtl/rename_map_ckpt_pkg.sv | 26 ++
 rtl/rat_ckpt_store.sv | 79 +++++++
 rtl/rename_map_ckpt.sv | 144 ++++++++++++++
 tb/tb_rename_map_ckpt.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rename_map_ckpt_pkg.sv
// Shared defaults, widths and helpers for the rename map with branch checkpoints.
package rename_map_ckpt_pkg;

  localparam int WAYS  = 4;
  localparam int PRF   = 64;
  localparam int AREGS = 32;
  localparam int NCKPT = 4;

  localparam int PW = $clog2(PRF);
  localparam int AW = $clog2(AREGS);
  localparam int CW = $clog2(NCKPT);

  typedef logic [AREGS-1:0][PW-1:0] map_t;
  typedef logic [CW-1:0]            ckid_t;

  // Circular pointer increment that also works for non power-of-two rings.
  function automatic int wrap_inc(input int p, input int n);
    return (p + 1 == n) ? 0 : p + 1;
  endfunction

  // Distance from a (older) to b (younger) around a ring of n entries.
  function automatic int ring_dist(input int b, input int a, input int n);
    return (b - a + n) % n;
  endfunction

endpackage

// File: rtl/rat_ckpt_store.sv
// Circular buffer of RAT snapshots, one per in-flight branch, with its
// head/tail/count bookkeeping. Truncation keeps the named entry and frees
// everything younger.
module rat_ckpt_store #(
  parameter int  NCKPT = rename_map_ckpt_pkg::NCKPT,
  parameter int  AREGS = rename_map_ckpt_pkg::AREGS,
  parameter int  PW    = rename_map_ckpt_pkg::PW,
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [AREGS-1:0][PW-1:0]  wr_map,
  input  logic [CW-1:0]             rd_id,
  output logic [AREGS-1:0][PW-1:0]  rd_map,
  input  logic                      trunc_en,
  input  logic                      free_en,
  output logic [CW-1:0]             head,
  output logic [CW-1:0]             tail,
  output logic [CW:0]               count
);
  import rename_map_ckpt_pkg::*;

  logic [AREGS-1:0][PW-1:0] slots [NCKPT];
  logic [CW-1:0]            head_next;
  logic [CW-1:0]            tail_next;
  logic [CW:0]              count_next;

  assign rd_map = slots[rd_id];

  // Snapshot storage: identity maps out of reset, written at the tail on allocation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NCKPT; c++) begin
        for (int a = 0; a < AREGS; a++) begin
          slots[c][a] <= PW'(a);
        end
      end
    end else if (wr_en) begin
      slots[tail] <= wr_map;
    end
  end

  // Pointer next state: clear wins, otherwise free and allocate/truncate combine.
  always_comb begin
    head_next  = head;
    tail_next  = tail;
    count_next = count;
    if (clear) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      if (free_en) head_next = CW'(wrap_inc(int'(head), NCKPT));
      if (trunc_en) begin
        tail_next  = CW'(wrap_inc(int'(rd_id), NCKPT));
        count_next = (CW+1)'(ring_dist(int'(rd_id), int'(head), NCKPT) + 1 - int'(free_en));
      end else begin
        if (wr_en) tail_next = CW'(wrap_inc(int'(tail), NCKPT));
        count_next = (CW+1)'(int'(count) + int'(wr_en) - int'(free_en));
      end
    end
  end

  // Pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head_next;
      tail  <= tail_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/rename_map_ckpt.sv
// Register alias table with intra-group forwarding, a retirement RAT for
// exception recovery, and branch checkpoints for mispredict recovery.
module rename_map_ckpt #(
  parameter int  WAYS  = rename_map_ckpt_pkg::WAYS,
  parameter int  PRF   = rename_map_ckpt_pkg::PRF,
  parameter int  AREGS = rename_map_ckpt_pkg::AREGS,
  parameter int  NCKPT = rename_map_ckpt_pkg::NCKPT,
  localparam int PW    = $clog2(PRF),
  localparam int AW    = $clog2(AREGS),
  localparam int CW    = $clog2(NCKPT)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     except,
  input  logic [WAYS-1:0]          rn_valid,
  input  logic [WAYS-1:0][AW-1:0]  rn_dest,
  input  logic [WAYS-1:0][PW-1:0]  rn_prf,
  input  logic [WAYS-1:0][AW-1:0]  rn_srca,
  input  logic [WAYS-1:0][AW-1:0]  rn_srcb,
  output logic [WAYS-1:0][PW-1:0]  rn_pa,
  output logic [WAYS-1:0][PW-1:0]  rn_pb,
  output logic [WAYS-1:0][PW-1:0]  rn_old,
  input  logic [WAYS-1:0]          ck_req,
  output logic [CW-1:0]            ck_id,
  output logic                     ck_stall,
  input  logic [WAYS-1:0]          rt_valid,
  input  logic [WAYS-1:0][AW-1:0]  rt_dest,
  input  logic [WAYS-1:0][PW-1:0]  rt_prf,
  input  logic                     rt_ck_free,
  input  logic                     br_mis,
  input  logic [CW-1:0]            br_ck_id,
  output logic [CW:0]              ck_count
);
  import rename_map_ckpt_pkg::*;

  typedef logic [AREGS-1:0][PW-1:0] rmap_t;

  rmap_t         rat;
  rmap_t         rrat;
  rmap_t         rat_next;
  rmap_t         rrat_next;
  rmap_t         grp_map;
  rmap_t         ck_map;
  rmap_t         restore_map;
  logic [CW-1:0] head;
  logic [CW-1:0] tail;
  logic [CW:0]   count;
  logic          rename_ok;
  logic          ck_alloc;

  // A group is committed only when nothing flushes it and it is not stalled.
  assign ck_stall  = (|ck_req) && (int'(count) == NCKPT);
  assign rename_ok = !except && !br_mis && !ck_stall;
  assign ck_alloc  = rename_ok && (|ck_req);
  assign ck_id     = tail;
  assign ck_count  = count;

  // Source/old lookups: older valid slots in the group override the RAT, youngest first.
  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      rn_pa[i]  = rat[rn_srca[i]];
      rn_pb[i]  = rat[rn_srcb[i]];
      rn_old[i] = rat[rn_dest[i]];
      for (int j = 0; j < i; j++) begin
        if (rn_valid[j] && (rn_dest[j] != '0)) begin
          if (rn_dest[j] == rn_srca[i]) rn_pa[i]  = rn_prf[j];
          if (rn_dest[j] == rn_srcb[i]) rn_pb[i]  = rn_prf[j];
          if (rn_dest[j] == rn_dest[i]) rn_old[i] = rn_prf[j];
        end
      end
    end
  end

  // Apply the group in slot order; the snapshot is taken right after the branch slot.
  always_comb begin
    grp_map = rat;
    ck_map  = rat;
    for (int k = 0; k < WAYS; k++) begin
      if (rn_valid[k] && (rn_dest[k] != '0)) grp_map[rn_dest[k]] = rn_prf[k];
      if (ck_req[k]) ck_map = grp_map;
    end
  end

  // Retirement map next state, youngest retiring slot wins.
  always_comb begin
    rrat_next = rrat;
    for (int k = 0; k < WAYS; k++) begin
      if (rt_valid[k] && (rt_dest[k] != '0)) rrat_next[rt_dest[k]] = rt_prf[k];
    end
  end

  // Speculative map next state: exception, then mispredict, then rename.
  always_comb begin
    rat_next = rat;
    if (except)         rat_next = rrat_next;
    else if (br_mis)    rat_next = restore_map;
    else if (rename_ok) rat_next = grp_map;
  end

  // Map registers reset to the identity mapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < AREGS; a++) begin
        rat[a]  <= PW'(a);
        rrat[a] <= PW'(a);
      end
    end else begin
      rat  <= rat_next;
      rrat <= rrat_next;
    end
  end

  rat_ckpt_store #(
    .NCKPT (NCKPT),
    .AREGS (AREGS),
    .PW    (PW)
  ) u_store (
    .clock    (clock),
    .reset    (reset),
    .clear    (except),
    .wr_en    (ck_alloc),
    .wr_map   (ck_map),
    .rd_id    (br_ck_id),
    .rd_map   (restore_map),
    .trunc_en (br_mis),
    .free_en  (rt_ck_free),
    .head     (head),
    .tail     (tail),
    .count    (count)
  );

  // Illegal control combinations from the pipeline.
  always @(posedge clock) begin
    if (!reset && !except) begin
      assert (!(br_mis && rt_ck_free && (br_ck_id == head)))
        else $error("mispredict on head checkpoint while it is being freed");
      assert (!((br_mis || rt_ck_free) && (count == '0)))
        else $error("checkpoint release or mispredict with no live checkpoint");
      assert ($onehot0(ck_req))
        else $error("more than one branch in a rename group");
    end
  end

endmodule

// File: tb/tb_rename_map_ckpt.sv
// Bench for rename_map_ckpt: table-driven forwarding vectors plus directed
// checkpoint, full, wrap, priority and reset sequences.
module tb_rename_map_ckpt;
  import rename_map_ckpt_pkg::*;

  localparam int W = 8;

  logic                     clock;
  logic                     reset;
  logic                     except;
  logic [WAYS-1:0]          rn_valid;
  logic [WAYS-1:0][AW-1:0]  rn_dest;
  logic [WAYS-1:0][PW-1:0]  rn_prf;
  logic [WAYS-1:0][AW-1:0]  rn_srca;
  logic [WAYS-1:0][AW-1:0]  rn_srcb;
  logic [WAYS-1:0][PW-1:0]  rn_pa;
  logic [WAYS-1:0][PW-1:0]  rn_pb;
  logic [WAYS-1:0][PW-1:0]  rn_old;
  logic [WAYS-1:0]          ck_req;
  logic [CW-1:0]            ck_id;
  logic                     ck_stall;
  logic [WAYS-1:0]          rt_valid;
  logic [WAYS-1:0][AW-1:0]  rt_dest;
  logic [WAYS-1:0][PW-1:0]  rt_prf;
  logic                     rt_ck_free;
  logic                     br_mis;
  logic [CW-1:0]            br_ck_id;
  logic [CW:0]              ck_count;

  rename_map_ckpt dut (
    .clock      (clock),
    .reset      (reset),
    .except     (except),
    .rn_valid   (rn_valid),
    .rn_dest    (rn_dest),
    .rn_prf     (rn_prf),
    .rn_srca    (rn_srca),
    .rn_srcb    (rn_srcb),
    .rn_pa      (rn_pa),
    .rn_pb      (rn_pb),
    .rn_old     (rn_old),
    .ck_req     (ck_req),
    .ck_id      (ck_id),
    .ck_stall   (ck_stall),
    .rt_valid   (rt_valid),
    .rt_dest    (rt_dest),
    .rt_prf     (rt_prf),
    .rt_ck_free (rt_ck_free),
    .br_mis     (br_mis),
    .br_ck_id   (br_ck_id),
    .ck_count   (ck_count)
  );

  // Clock and watchdog.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "simulation time limit reached");
  end

  // Scoreboard.
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic sb_push(input string nm, input int v);
    exp_q.push_back(W'(v));
    name_q.push_back(nm);
  endtask

  task automatic sb_pop_cmp(input logic [W-1:0] act);
    logic [W-1:0] e;
    string        nm;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL sb_underflow: got %0d with nothing expected", act);
      return;
    end
    e  = exp_q.pop_front();
    nm = name_q.pop_front();
    if (act !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, e);
    end
  endtask

  task automatic check(input string nm, input int e, input logic [W-1:0] act);
    sb_push(nm, e);
    sb_pop_cmp(act);
  endtask

  // Driver tasks.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    except     = 1'b0;
    rn_valid   = '0;
    rn_dest    = '0;
    rn_prf     = '0;
    rn_srca    = '0;
    rn_srcb    = '0;
    ck_req     = '0;
    rt_valid   = '0;
    rt_dest    = '0;
    rt_prf     = '0;
    rt_ck_free = 1'b0;
    br_mis     = 1'b0;
    br_ck_id   = '0;
  endtask

  task automatic set_rn(input int i, input bit v, input int d, input int p);
    rn_valid[i] = v;
    rn_dest[i]  = AW'(d);
    rn_prf[i]   = PW'(p);
  endtask

  task automatic set_rt(input int i, input int d, input int p);
    rt_valid[i] = 1'b1;
    rt_dest[i]  = AW'(d);
    rt_prf[i]   = PW'(p);
  endtask

  // Read four RAT entries through slot sources with no renames in flight.
  task automatic probe(input string nm, input int s0, input int s1, input int s2, input int s3,
                       input int e0, input int e1, input int e2, input int e3);
    rn_valid   = '0;
    ck_req     = '0;
    rn_srca[0] = AW'(s0);
    rn_srca[1] = AW'(s1);
    rn_srca[2] = AW'(s2);
    rn_srca[3] = AW'(s3);
    sb_push($sformatf("%s_r%0d", nm, s0), e0);
    sb_push($sformatf("%s_r%0d", nm, s1), e1);
    sb_push($sformatf("%s_r%0d", nm, s2), e2);
    sb_push($sformatf("%s_r%0d", nm, s3), e3);
    #1;
    for (int i = 0; i < WAYS; i++) sb_pop_cmp(W'(rn_pa[i]));
  endtask

  // Forwarding vectors, each applied against an identity RAT.
  typedef struct {
    logic [WAYS-1:0] valid;
    int dest[4];
    int prf[4];
    int srca[4];
    int srcb[4];
    int pa[4];
    int pb[4];
    int old[4];
    int psrc[4];
    int pexp[4];
  } vec_t;

  localparam int NV = 5;
  vec_t tv[NV];

  initial begin
    // Two writes to r3, a dest-0 slot, then r5.
    tv[0].valid = 4'b1111;
    tv[0].dest = '{3, 3, 0, 5};    tv[0].prf  = '{40, 41, 42, 43};
    tv[0].srca = '{3, 3, 3, 3};    tv[0].srcb = '{5, 0, 5, 0};
    tv[0].pa   = '{3, 40, 41, 41}; tv[0].pb   = '{5, 0, 5, 0};
    tv[0].old  = '{3, 40, 0, 5};
    tv[0].psrc = '{3, 0, 5, 1};    tv[0].pexp = '{41, 0, 43, 1};
    // Invalid slots neither forward nor write.
    tv[1].valid = 4'b0101;
    tv[1].dest = '{7, 8, 7, 9};    tv[1].prf  = '{50, 51, 52, 53};
    tv[1].srca = '{7, 7, 8, 7};    tv[1].srcb = '{9, 8, 9, 9};
    tv[1].pa   = '{7, 50, 8, 52};  tv[1].pb   = '{9, 8, 9, 9};
    tv[1].old  = '{7, 8, 50, 9};
    tv[1].psrc = '{7, 8, 9, 0};    tv[1].pexp = '{52, 8, 9, 0};
    // Same destination in every slot.
    tv[2].valid = 4'b1111;
    tv[2].dest = '{12, 12, 12, 12}; tv[2].prf  = '{20, 21, 22, 23};
    tv[2].srca = '{12, 12, 12, 12}; tv[2].srcb = '{1, 2, 3, 4};
    tv[2].pa   = '{12, 20, 21, 22}; tv[2].pb   = '{1, 2, 3, 4};
    tv[2].old  = '{12, 20, 21, 22};
    tv[2].psrc = '{12, 1, 2, 3};    tv[2].pexp = '{23, 1, 2, 3};
    // Empty group.
    tv[3].valid = 4'b0000;
    tv[3].dest = '{1, 2, 3, 4};     tv[3].prf  = '{60, 61, 62, 63};
    tv[3].srca = '{1, 2, 3, 4};     tv[3].srcb = '{31, 30, 29, 0};
    tv[3].pa   = '{1, 2, 3, 4};     tv[3].pb   = '{31, 30, 29, 0};
    tv[3].old  = '{1, 2, 3, 4};
    tv[3].psrc = '{1, 2, 3, 4};     tv[3].pexp = '{1, 2, 3, 4};
    // r0 destinations and the top architectural register.
    tv[4].valid = 4'b1111;
    tv[4].dest = '{0, 0, 31, 31};   tv[4].prf  = '{44, 45, 46, 47};
    tv[4].srca = '{0, 0, 0, 31};    tv[4].srcb = '{31, 31, 31, 0};
    tv[4].pa   = '{0, 0, 0, 46};    tv[4].pb   = '{31, 31, 31, 0};
    tv[4].old  = '{0, 0, 31, 46};
    tv[4].psrc = '{0, 31, 30, 0};   tv[4].pexp = '{0, 47, 30, 0};
  end

  // Main sequence.
  initial begin
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state and identity lookups on random sources.
    for (int i = 0; i < WAYS; i++) begin
      rn_srca[i] = AW'($urandom_range(0, AREGS-1));
      rn_srcb[i] = AW'($urandom_range(0, AREGS-1));
      rn_dest[i] = AW'($urandom_range(0, AREGS-1));
    end
    for (int i = 0; i < WAYS; i++) begin
      sb_push($sformatf("rst_pa%0d", i), int'(rn_srca[i]));
      sb_push($sformatf("rst_pb%0d", i), int'(rn_srcb[i]));
      sb_push($sformatf("rst_old%0d", i), int'(rn_dest[i]));
    end
    #1;
    for (int i = 0; i < WAYS; i++) begin
      sb_pop_cmp(W'(rn_pa[i]));
      sb_pop_cmp(W'(rn_pb[i]));
      sb_pop_cmp(W'(rn_old[i]));
    end
    check("rst_ck_count", 0, W'(ck_count));
    check("rst_ck_stall", 0, W'(ck_stall));
    check("rst_ck_id", 0, W'(ck_id));
    tick();

    // Table-driven forwarding vectors.
    for (int v = 0; v < NV; v++) begin
      clear_inputs();
      rn_valid = tv[v].valid;
      for (int i = 0; i < WAYS; i++) begin
        rn_dest[i] = AW'(tv[v].dest[i]);
        rn_prf[i]  = PW'(tv[v].prf[i]);
        rn_srca[i] = AW'(tv[v].srca[i]);
        rn_srcb[i] = AW'(tv[v].srcb[i]);
      end
      for (int i = 0; i < WAYS; i++) sb_push($sformatf("v%0d_pa%0d", v, i), tv[v].pa[i]);
      for (int i = 0; i < WAYS; i++) sb_push($sformatf("v%0d_pb%0d", v, i), tv[v].pb[i]);
      for (int i = 0; i < WAYS; i++) sb_push($sformatf("v%0d_old%0d", v, i), tv[v].old[i]);
      #1;
      for (int i = 0; i < WAYS; i++) sb_pop_cmp(W'(rn_pa[i]));
      for (int i = 0; i < WAYS; i++) sb_pop_cmp(W'(rn_pb[i]));
      for (int i = 0; i < WAYS; i++) sb_pop_cmp(W'(rn_old[i]));
      tick();
      clear_inputs();
      probe($sformatf("v%0d_rat", v), tv[v].psrc[0], tv[v].psrc[1], tv[v].psrc[2], tv[v].psrc[3],
            tv[v].pexp[0], tv[v].pexp[1], tv[v].pexp[2], tv[v].pexp[3]);
      tick();
      clear_inputs();
      except = 1'b1;
      tick();
    end

    // Checkpoint after slot 1, then mispredict back to it with a dropped rename.
    clear_inputs();
    set_rn(0, 1'b1, 1, 49);
    set_rn(1, 1'b1, 7, 50);
    set_rn(2, 1'b1, 2, 52);
    set_rn(3, 1'b1, 7, 51);
    ck_req = 4'b0010;
    #1;
    check("ckpt_id", 0, W'(ck_id));
    check("ckpt_stall", 0, W'(ck_stall));
    tick();
    clear_inputs();
    probe("ckpt_pre", 7, 1, 2, 9, 51, 49, 52, 9);
    check("ckpt_count", 1, W'(ck_count));
    tick();
    clear_inputs();
    br_mis   = 1'b1;
    br_ck_id = '0;
    set_rn(0, 1'b1, 9, 33);
    tick();
    clear_inputs();
    probe("ckpt_restore", 7, 1, 2, 9, 50, 49, 2, 9);
    check("ckpt_mis_count", 1, W'(ck_count));
    tick();
    clear_inputs();
    except = 1'b1;
    tick();

    // Fill all checkpoints, stall alongside a free, then allocate again.
    for (int c = 0; c < NCKPT; c++) begin
      clear_inputs();
      set_rn(0, 1'b1, 10, 20 + c);
      ck_req = 4'b0001;
      #1;
      check($sformatf("full_alloc_id%0d", c), c, W'(ck_id));
      check($sformatf("full_alloc_stall%0d", c), 0, W'(ck_stall));
      tick();
    end
    clear_inputs();
    set_rn(0, 1'b1, 10, 30);
    ck_req     = 4'b0001;
    rt_ck_free = 1'b1;
    #1;
    check("full_count4", 4, W'(ck_count));
    check("full_stall", 1, W'(ck_stall));
    tick();
    clear_inputs();
    probe("full_hold", 10, 0, 0, 0, 23, 0, 0, 0);
    check("full_count3", 3, W'(ck_count));
    tick();
    clear_inputs();
    ck_req = 4'b0001;
    #1;
    check("full_retry_stall", 0, W'(ck_stall));
    check("full_retry_id", 0, W'(ck_id));
    tick();
    clear_inputs();
    #1;
    check("full_retry_count", 4, W'(ck_count));
    tick();
    clear_inputs();
    except = 1'b1;
    tick();

    // Move head to 3, allocate ids 3,0,1, then truncate to id 0.
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      ck_req = 4'b0001;
      tick();
    end
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      rt_ck_free = 1'b1;
      tick();
    end
    clear_inputs();
    #1;
    check("wrap_empty", 0, W'(ck_count));
    for (int c = 0; c < 3; c++) begin
      clear_inputs();
      set_rn(0, 1'b1, 4, 34 + c);
      ck_req = 4'b0001;
      #1;
      check($sformatf("wrap_id%0d", c), (3 + c) % NCKPT, W'(ck_id));
      tick();
    end
    clear_inputs();
    br_mis   = 1'b1;
    br_ck_id = CW'(0);
    tick();
    clear_inputs();
    rn_srca[0] = AW'(4);
    ck_req     = 4'b0001;
    #1;
    check("wrap_restore_r4", 35, W'(rn_pa[0]));
    check("wrap_count", 2, W'(ck_count));
    check("wrap_tail", 1, W'(ck_id));
    tick();
    clear_inputs();
    #1;
    check("wrap_realloc_count", 3, W'(ck_count));
    tick();
    clear_inputs();
    except = 1'b1;
    tick();

    // Exception beats mispredict and rename; same-cycle retires land in both maps.
    clear_inputs();
    set_rn(0, 1'b1, 5, 12);
    ck_req = 4'b0001;
    tick();
    clear_inputs();
    except   = 1'b1;
    br_mis   = 1'b1;
    br_ck_id = '0;
    set_rn(0, 1'b1, 6, 61);
    set_rt(0, 5, 57);
    set_rt(1, 8, 58);
    set_rt(2, 5, 60);
    set_rt(3, 0, 59);
    tick();
    clear_inputs();
    probe("prio_rat", 5, 8, 0, 6, 60, 58, 0, 6);
    check("prio_count", 0, W'(ck_count));
    check("prio_id", 0, W'(ck_id));
    tick();
    clear_inputs();
    except = 1'b1;
    tick();
    clear_inputs();
    probe("prio_rrat", 5, 8, 1, 6, 60, 58, 1, 6);
    tick();

    // Asynchronous reset in the middle of traffic.
    clear_inputs();
    set_rn(0, 1'b1, 3, 40);
    ck_req = 4'b0001;
    tick();
    clear_inputs();
    br_mis   = 1'b1;
    br_ck_id = '0;
    except   = 1'b1;
    probe("mid_pre", 3, 5, 8, 0, 40, 60, 58, 0);
    reset = 1'b1;
    #1;
    check("mid_rst_r3", 3, W'(rn_pa[0]));
    check("mid_rst_r5", 5, W'(rn_pa[1]));
    check("mid_rst_count", 0, W'(ck_count));
    tick();
    clear_inputs();
    reset = 1'b0;
    probe("mid_post", 3, 5, 8, 0, 3, 5, 8, 0);
    check("mid_post_count", 0, W'(ck_count));
    tick();

    // Final report.
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got %0d queued expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
